// File: rtl/fx_mac_feeder_pkg.sv
// Shared constants, state encoding and sizing helper for the fx_mac feeder.
package fx_mac_feeder_pkg;

    localparam int unsigned FX_WIDTH   = 8;
    localparam int unsigned FX_K       = 9;
    localparam int unsigned FX_GAP_MIN = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_GAP   = 2'd2
    } fx_state_e;

    // Index width for a K-entry table, never narrower than one bit.
    function automatic int unsigned fx_aw(input int unsigned k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

endpackage

// File: rtl/fx_mac_feeder_win_bank.sv
// Ping-pong activation window buffer: two K-deep banks, fill side handshake and full flags.
module fx_mac_feeder_win_bank
    import fx_mac_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = FX_WIDTH,
    parameter int unsigned K     = FX_K,
    localparam int unsigned AW   = fx_aw(K)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [WIDTH-1:0] s_data,
    input  logic             db,
    input  logic             rel,
    input  logic [AW-1:0]    rd_idx,
    output logic [WIDTH-1:0] rd_data,
    output logic [1:0]       full,
    output logic [1:0]       full_nxt_c
);

    logic             fb_q, fb_d;
    logic [AW-1:0]    fill_cnt_q, fill_cnt_d;
    logic [1:0]       full_q, full_d;
    logic [WIDTH-1:0] mem_q [2][K];
    logic             xfer;

    assign s_rdy      = ~full_q[fb_q];
    assign xfer       = s_vld & s_rdy;
    assign full       = full_q;
    assign full_nxt_c = full_d;
    assign rd_data    = mem_q[db][rd_idx];

    // Fill pointer advance; drain release and fill completion always hit different banks.
    always_comb begin
        fb_d       = fb_q;
        fill_cnt_d = fill_cnt_q;
        full_d     = full_q;
        if (rel) begin
            full_d[db] = 1'b0;
        end
        if (xfer) begin
            if (fill_cnt_q == AW'(K - 1)) begin
                full_d[fb_q] = 1'b1;
                fb_d         = ~fb_q;
                fill_cnt_d   = '0;
            end else begin
                fill_cnt_d = fill_cnt_q + AW'(1);
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            fb_q       <= 1'b0;
            fill_cnt_q <= '0;
            full_q     <= '0;
        end else begin
            fb_q       <= fb_d;
            fill_cnt_q <= fill_cnt_d;
            full_q     <= full_d;
        end
    end

    // Window storage; contents are don't-care until the bank is marked full.
    always_ff @(posedge clk) begin
        if (xfer) begin
            mem_q[fb_q][fill_cnt_q] <= s_data;
        end
    end

endmodule

// File: rtl/fx_mac_feeder.sv
// Sequencer that replays buffered activation windows with weights as fixed K-beat bursts.
module fx_mac_feeder
    import fx_mac_feeder_pkg::*;
#(
    parameter int unsigned WIDTH = FX_WIDTH,
    parameter int unsigned K     = FX_K,
    parameter int unsigned GAP   = FX_GAP_MIN,
    localparam int unsigned AW   = fx_aw(K),
    localparam int unsigned GW   = fx_aw(GAP)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             s_vld,
    output logic             s_rdy,
    input  logic [WIDTH-1:0] s_data,
    input  logic             w_we,
    input  logic [AW-1:0]    w_addr,
    input  logic [WIDTH-1:0] w_data,
    output logic             vld_o,
    output logic [WIDTH-1:0] win,
    output logic [WIDTH-1:0] din,
    output logic             busy,
    output logic             w_err
);

    fx_state_e        state_q, state_d;
    logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
    logic             db_q, db_d;
    logic             vld_q, vld_d;
    logic [WIDTH-1:0] win_q, win_d;
    logic [WIDTH-1:0] din_q, din_d;
    logic             busy_q, busy_d;
    logic             w_err_q, w_err_d;
    logic [WIDTH-1:0] wreg_q [K];
    logic [WIDTH-1:0] wreg_d [K];

    logic             rel;
    logic [WIDTH-1:0] rd_data;
    logic [1:0]       full;
    logic [1:0]       full_nxt_c;

    fx_mac_feeder_win_bank #(
        .WIDTH (WIDTH),
        .K     (K)
    ) u_bank (
        .clk        (clk),
        .rstn       (rstn),
        .s_vld      (s_vld),
        .s_rdy      (s_rdy),
        .s_data     (s_data),
        .db         (db_q),
        .rel        (rel),
        .rd_idx     (rd_cnt_q),
        .rd_data    (rd_data),
        .full       (full),
        .full_nxt_c (full_nxt_c)
    );

    assign vld_o = vld_q;
    assign win   = win_q;
    assign din   = din_q;
    assign busy  = busy_q;
    assign w_err = w_err_q;

    // Drain sequencing, beat generation and weight-table updates.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        gap_cnt_d = gap_cnt_q;
        db_d      = db_q;
        rel       = 1'b0;
        vld_d     = 1'b0;
        win_d     = '0;
        din_d     = '0;
        w_err_d   = w_err_q;
        wreg_d    = wreg_q;

        unique case (state_q)
            ST_IDLE: begin
                if (full[db_q]) begin
                    state_d  = ST_BURST;
                    rd_cnt_d = '0;
                end
            end
            ST_BURST: begin
                vld_d = 1'b1;
                win_d = wreg_q[rd_cnt_q];
                din_d = rd_data;
                if (rd_cnt_q == AW'(K - 1)) begin
                    rel       = 1'b1;
                    db_d      = ~db_q;
                    state_d   = ST_GAP;
                    gap_cnt_d = '0;
                    rd_cnt_d  = '0;
                end else begin
                    rd_cnt_d = rd_cnt_q + AW'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GW'(GAP - 1)) begin
                    state_d  = full[db_q] ? ST_BURST : ST_IDLE;
                    rd_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Weights may only change outside a burst so a burst never sees mixed weights.
        if (w_we) begin
            if ((state_q == ST_BURST) || (32'(w_addr) >= K)) begin
                w_err_d = 1'b1;
            end else begin
                wreg_d[w_addr] = w_data;
            end
        end

        busy_d = (state_d != ST_IDLE) || (|full_nxt_c);
    end

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= ST_IDLE;
            rd_cnt_q  <= '0;
            gap_cnt_q <= '0;
            db_q      <= 1'b0;
            vld_q     <= 1'b0;
            win_q     <= '0;
            din_q     <= '0;
            busy_q    <= 1'b0;
            w_err_q   <= 1'b0;
            wreg_q    <= '{default: '0};
        end else begin
            state_q   <= state_d;
            rd_cnt_q  <= rd_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            db_q      <= db_d;
            vld_q     <= vld_d;
            win_q     <= win_d;
            din_q     <= din_d;
            busy_q    <= busy_d;
            w_err_q   <= w_err_d;
            wreg_q    <= wreg_d;
        end
    end

endmodule
